// File: rtl/mmu_spsram_param_if.sv
// Single-port SRAM bus: address, active-low enables, write data/mask and read data.
interface mmu_spsram_param_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 88
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic [DATA_WIDTH-1:0] D;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] Q;

  modport master (output A, CEN, D, GWEN, WEN, input Q);
  modport slave  (input A, CEN, D, GWEN, WEN, output Q);
endinterface

// File: rtl/mmu_spsram_param.sv
// Parameterized single-port synchronous SRAM for the MMU JTLB arrays.
// Active-low chip/global write enables, per-bit write mask, one-cycle registered read.
module mmu_spsram_param #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 88
) (
  input  logic                 CLK,
  input  logic                 RST,
  mmu_spsram_param_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] q_reg;

  // Reset clears only the output register and suppresses that edge's access;
  // stored words survive. Writes never disturb Q (no write-through).
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= '0;
    end else if (!bus.CEN) begin
      if (!bus.GWEN) begin
        mem[bus.A] <= (mem[bus.A] & bus.WEN) | (bus.D & ~bus.WEN);
      end else begin
        q_reg <= mem[bus.A];
      end
    end
  end

  assign bus.Q = q_reg;
endmodule

// File: tb/tb_mmu_spsram_param.sv
// Randomized and directed check of mmu_spsram_param against a behavioural model.
module tb_mmu_spsram_param;
  localparam int AW    = 7;
  localparam int DW    = 88;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmu_spsram_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mmu_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_q;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  // Drive one clock of stimulus, advance the model, then compare Q after the edge.
  task automatic cycle(input string tag, input logic r, input logic cen, input logic gwen,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
    rst      = r;
    bus.CEN  = cen;
    bus.GWEN = gwen;
    bus.A    = a;
    bus.D    = d;
    bus.WEN  = wen;
    @(posedge clk);
    if (r) begin
      model_q = '0;
    end else if (!cen && !gwen) begin
      for (int b = 0; b < DW; b++)
        if (wen[b] == 1'b0) model_mem[a][b] = d[b];
    end else if (!cen && gwen) begin
      model_q = model_mem[a];
    end
    #1;
    check(tag, bus.Q, model_q);
  endtask

  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] ZERO = '0;

  initial begin
    logic [DW-1:0] fives, aas;
    fives = {(DW/2){2'b01}};
    aas   = {(DW/2){2'b10}};
    model_q = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    cycle("reset", 1, 1, 1, 0, 0, ONES);
    cycle("reset", 1, 0, 0, 0, 0, ZERO);

    // Enabled write and readback
    for (int i = 0; i < 10; i++) begin
      cycle("wr", 0, 0, 0, AW'(i), DW'(i), ZERO);
      cycle("rd", 0, 0, 1, AW'(i), 0, ONES);
      check("rd_val", bus.Q, DW'(i));
    end

    // Seed 10..19 with known contents, then attempt deselected writes
    for (int i = 10; i < 20; i++) cycle("seed", 0, 0, 0, AW'(i), DW'(i) << 40, ZERO);
    cycle("rd9", 0, 0, 1, 9, 0, ONES);
    for (int i = 10; i < 20; i++) begin
      cycle("desel_wr", 0, 1, 0, AW'(i), DW'(i), ZERO);
      check("desel_hold", bus.Q, DW'(9));
    end
    for (int i = 10; i < 20; i++) cycle("desel_rd", 0, 1, 1, AW'(i), 0, ONES);
    check("desel_rd_hold", bus.Q, DW'(9));
    for (int i = 10; i < 20; i++) begin
      cycle("prior_rd", 0, 0, 1, AW'(i), 0, ONES);
      check("prior_val", bus.Q, DW'(i) << 40);
    end

    // Bit mask: only the top k bits get written
    for (int k = 0; k < DW; k++) begin
      cycle("mask_clr", 0, 0, 0, 20, ZERO, ZERO);
      cycle("mask_wr", 0, 0, 0, 20, ONES, ONES >> k);
      cycle("mask_rd", 0, 0, 1, 20, 0, ONES);
      check("mask_val", bus.Q, ~(ONES >> k));
    end

    // Full-depth sweep
    for (int i = 0; i < DEPTH; i++) begin
      cycle("sweep_wr", 0, 0, 0, AW'(i), ONES, ZERO);
      cycle("sweep_rd", 0, 0, 1, AW'(i), 0, ZERO);
      check("sweep_val", bus.Q, ONES);
    end

    // Reset mid-sequence cancels the write only
    cycle("pre_rst_rd", 0, 0, 1, 5, 0, ONES);
    cycle("rst_q", 1, 0, 0, 3, fives, ZERO);
    check("rst_zero", bus.Q, ZERO);
    cycle("post_rst_rd", 0, 0, 1, 3, 0, ONES);
    check("rst_mem_kept", bus.Q, ONES);

    // Q holds through a write
    cycle("w1", 0, 0, 0, 1, DW'(1), ZERO);
    cycle("r1", 0, 0, 1, 1, 0, ONES);
    cycle("w2", 0, 0, 0, 2, aas, ZERO);
    check("q_hold_wr", bus.Q, DW'(1));
    cycle("r2", 0, 0, 1, 2, 0, ONES);
    check("q_after_rd", bus.Q, aas);

    // Random traffic; every address is defined after the sweep
    for (int n = 0; n < 2000; n++) begin
      logic [DW-1:0] wen;
      int mode;
      mode = $urandom_range(0, 3);
      wen = (mode == 0) ? ZERO : (mode == 1) ? ONES : rand_word();
      cycle("rand", ($urandom_range(0, 31) == 0), $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)), rand_word(), wen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmu_spsram_param.md
Name: mmu_spsram_param

Overview:
- Parameterized single-port synchronous SRAM behavioural model for the MMU JTLB data and tag arrays.
- Active-low chip enable, global write enable and per-bit write mask; one-cycle registered read.
- Fixed configurations are thin wrappers that set parameters only:
  - aq_umc_spsram_128x88: ADDR_WIDTH=7, DATA_WIDTH=88
  - aq_umc_spsram_128x98: ADDR_WIDTH=7, DATA_WIDTH=98
  - aq_umc_spsram_256x88: ADDR_WIDTH=8, DATA_WIDTH=88

Parameters:
ADDR_WIDTH, 7, address width; depth = 2**ADDR_WIDTH words.
DATA_WIDTH, 88, word width; the WEN mask is the same width.

Ports:
CLK   input   1           single clock; all activity on the rising edge.
RST   input   1           reset, synchronous, active-high.
A     input   ADDR_WIDTH  word address.
CEN   input   1           chip enable, active-low.
D     input   DATA_WIDTH  write data.
GWEN  input   1           global write enable, active-low.
WEN   input   DATA_WIDTH  per-bit write enable, active-low (0 = write that bit).
Q     output  DATA_WIDTH  registered read data.

Behaviour:
- Reset:
  - On a rising edge with RST=1: Q <= 0 and no array write occurs, regardless of CEN/GWEN.
  - Array contents are not cleared by reset.
  - Contents are undefined (X in simulation) until written.
- Operation on each rising edge with RST=0:
  - CEN=1 (deselected): no write, no read; Q holds its previous value; A, D, GWEN and WEN are ignored.
  - CEN=0, GWEN=0 (write): for each bit b, mem[A][b] <= D[b] if WEN[b]=0, otherwise unchanged. Q holds its previous value (no write-through).
  - CEN=0, GWEN=1 (read): Q <= mem[A]. WEN is ignored.
- Latency and ordering:
  - Read latency is one cycle: data addressed at edge N is visible on Q after edge N.
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Bit-mask rules:
  - WEN all 0 writes the full word; WEN all 1 with GWEN=0 leaves memory unchanged.
  - Partial masks update only the selected bits.
- Addressing: A covers the full depth, so there is no out-of-range case; address 2**ADDR_WIDTH-1 is valid.
- Q changes only on a rising CLK edge; no combinational path from inputs to Q.
- A reset in the middle of a write/read sequence cancels that edge's operation only. Previously written words remain readable after RST deasserts.
- Storage is a plain register array: DATA_WIDTH x 2**ADDR_WIDTH, one always block on posedge CLK, with a bitwise masked merge for writes.

Test Plan:
1. Enabled write/readback:
   - For i=0..9: write D=i to A=i with CEN=0, GWEN=0, WEN=0; next cycle set GWEN=1, WEN=all-1 to read.
   - Required: Q==i one cycle after the read edge.
2. Deselected write ignored:
   - Hold CEN=1; for i=10..19 drive A=i, D=i, GWEN=0, WEN=0; then read with CEN=1.
   - Required: Q stays at the last read value (9), never equal to i; a later CEN=0 read of A=10..19 returns the prior contents, not i.
3. Bit mask:
   - Write all-0 to A=20; then write D=all-1 with WEN=all-1>>k, for k=0..DATA_WIDTH-1, each k starting from all-0.
   - Required: a readback of A=20 shows only the top k bits set; with WEN=all-1 the word stays all-0.
4. Full-depth sweep:
   - Write all-1 to every address 0..2**ADDR_WIDTH-1, reading each back.
   - Required: Q == all-1 for every address, including the last (127 or 255).
5. Reset:
   - After reading a non-zero word, assert RST for one edge while CEN=0, GWEN=0, D=0x55.., A=3.
   - Required: Q==0; mem[3] is unchanged (a readback after RST deasserts shows the old value).
6. Q hold during write:
   - Read A=1 (value 1), then write A=2 with 0xAA.. on the next edge.
   - Required: Q remains 1 through the write cycle; it updates only on the next read.
